oc_uart_tx_arbiter: RTL and testbench

Message-granular round-robin arbiter that shares one UART transmit byte stream between several on-chip requesters, e.g. the CSR console and the chipmon/IIC offload debug printers. It sits between the requesters' byte streams and the UART TX serializer, so that messages from different sources never interleave on USB_UART or the MSP UART. An optional idle timeout stops a stalled requester from holding the UART.

---
 rtl/oc_uart_tx_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_oc_uart_tx_arbiter.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oc_uart_tx_arbiter.sv
// oc_uart_tx_arbiter
// Message-granular round-robin arbiter sharing one UART TX byte stream between
// several on-chip requesters. Once a requester is granted, its bytes pass straight
// through to the serializer until it sends a byte flagged reqLast or equal to
// EolByte. Messages from different requesters therefore never interleave.
//
// Optional feature: define OC_UART_TX_ARB_TIMEOUT_EN to build an idle counter.
// The counter force-releases an owner that stops presenting bytes for
// TimeoutCycles cycles. Each forced release is counted in timeoutCount.
// Without the macro, grant is held until the message ends and timeoutCount is 0.
//
// Ports:
//   clock        clock for all logic
//   resetN       asynchronous active-low reset
//   reqValid     per-requester byte valid
//   reqData      per-requester byte, requester i on bits [8i+7:8i]
//   reqLast      per-requester end-of-message flag
//   reqReady     per-requester accept (only the owner can be ready)
//   txValid      byte valid toward the serializer
//   txData       byte toward the serializer
//   txReady      serializer accept
//   grant        one-hot current owner, zero when idle
//   busy         a message is in progress
//   timeoutCount saturating count of forced releases
module oc_uart_tx_arbiter #(
  parameter int unsigned RequesterCount = 2,
  parameter logic [7:0]  EolByte        = 8'h0A,
  parameter int unsigned TimeoutCycles  = 4096
) (
  input  logic                          clock,
  input  logic                          resetN,
  input  logic [RequesterCount-1:0]     reqValid,
  input  logic [8*RequesterCount-1:0]   reqData,
  input  logic [RequesterCount-1:0]     reqLast,
  output logic [RequesterCount-1:0]     reqReady,
  output logic                          txValid,
  output logic [7:0]                    txData,
  input  logic                          txReady,
  output logic [RequesterCount-1:0]     grant,
  output logic                          busy,
  output logic [15:0]                   timeoutCount
);

  localparam int unsigned IdxW = (RequesterCount > 1) ? $clog2(RequesterCount) : 1;

  if (RequesterCount < 2 || RequesterCount > 8 || TimeoutCycles < 2) begin : g_bad_param
    $error("oc_uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [0:0] {StIdle, StGranted} state_e;

  state_e                    state_q, state_d;
  logic [RequesterCount-1:0] grant_q, grant_d;
  // While granted, last_grant_q is the current owner.
  logic [IdxW-1:0]           last_grant_q, last_grant_d;

  logic                      owner_valid;
  logic                      owner_last;
  logic [7:0]                owner_data;
  logic [IdxW+2:0]           data_lsb;
  logic                      xfer;
  logic                      msg_end;
  logic                      timeout_hit;

  logic                      pick_found;
  logic [IdxW-1:0]           pick_idx;

  assign data_lsb    = {last_grant_q, 3'b000};
  assign owner_valid = reqValid[last_grant_q];
  assign owner_last  = reqLast[last_grant_q];
  assign owner_data  = reqData[data_lsb +: 8];

  assign xfer    = (state_q == StGranted) && owner_valid && txReady;
  assign msg_end = xfer && (owner_last || (owner_data == EolByte));

  // Round-robin search starting just after the previous owner.
  always_comb begin
    int unsigned cand;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 1; k <= RequesterCount; k++) begin
      cand = (32'(last_grant_q) + k) % RequesterCount;
      if (!pick_found && reqValid[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

`ifdef OC_UART_TX_ARB_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic [15:0] timeout_count_q, timeout_count_d;

  // Counts consecutive owner-idle cycles; a txReady stall with valid data is not idle.
  always_comb begin
    idle_cnt_d  = idle_cnt_q;
    timeout_hit = 1'b0;
    if (state_q != StGranted || owner_valid) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == 32'(TimeoutCycles - 1)) begin
      timeout_hit = 1'b1;
      idle_cnt_d  = '0;
    end else begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
  end

  always_comb begin
    timeout_count_d = timeout_count_q;
    if (timeout_hit && (timeout_count_q != 16'hFFFF)) begin
      timeout_count_d = timeout_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      idle_cnt_q      <= '0;
      timeout_count_q <= '0;
    end else begin
      idle_cnt_q      <= idle_cnt_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign timeoutCount = timeout_count_q;
`else
  assign timeout_hit  = 1'b0;
  assign timeoutCount = '0;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d           = StGranted;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          last_grant_d      = pick_idx;
        end
      end
      StGranted: begin
        if (msg_end || timeout_hit) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdxW'(RequesterCount - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Zero-latency pass-through from the owner to the serializer.
  always_comb begin
    txValid  = 1'b0;
    txData   = '0;
    reqReady = '0;
    if (state_q == StGranted) begin
      txValid                = owner_valid;
      txData                 = owner_data;
      reqReady[last_grant_q] = txReady;
    end
  end

  assign busy  = (state_q == StGranted);
  assign grant = grant_q;

endmodule

// File: tb/tb_oc_uart_tx_arbiter.sv
// Bench for oc_uart_tx_arbiter with four requesters and a 16-cycle timeout.
// Directed scenarios use hand-derived constants; the random scenario compares
// every cycle against a message-level reference model held in the bench.
module tb_oc_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TC = 16;
  localparam logic [7:0] Eol = 8'h0A;
`ifdef OC_UART_TX_ARB_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           resetN;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_ready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [15:0]    timeout_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: message in progress, owner, previous owner, idle run, releases.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_idle;
  int m_tcount;

  always #5 clock = ~clock;

  oc_uart_tx_arbiter #(
    .RequesterCount (N),
    .EolByte        (Eol),
    .TimeoutCycles  (TC)
  ) dut (
    .clock        (clock),
    .resetN       (resetN),
    .reqValid     (req_valid),
    .reqData      (req_data),
    .reqLast      (req_last),
    .reqReady     (req_ready),
    .txValid      (tx_valid),
    .txData       (tx_data),
    .txReady      (tx_ready),
    .grant        (grant),
    .busy         (busy),
    .timeoutCount (timeout_count)
  );

  task automatic model_reset();
    m_busy   = 1'b0;
    m_owner  = 0;
    m_last   = N - 1;
    m_idle   = 0;
    m_tcount = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_next();
    bit         found;
    bit         v;
    logic [7:0] d;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!found && req_valid[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_last  = c;
          m_busy  = 1'b1;
          m_idle  = 0;
        end
      end
    end else begin
      v = req_valid[m_owner];
      d = req_data[8*m_owner +: 8];
      if (v && tx_ready && (req_last[m_owner] || d == Eol)) begin
        m_busy = 1'b0;
        m_idle = 0;
      end else if (TimeoutEn && !v) begin
        if (m_idle == TC - 1) begin
          m_busy = 1'b0;
          m_idle = 0;
          if (m_tcount < 65535) m_tcount++;
        end else begin
          m_idle++;
        end
      end else begin
        m_idle = 0;
      end
    end
  endtask

  task automatic apply_reset();
    resetN    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetN    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    #2;
    n_checks++;
    if (grant !== 4'b0000) $display("FAIL reset_grant: got %b expected 0000", grant);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_checks++;
    if (tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %b expected 0", tx_valid);
    else n_pass++;
    n_checks++;
    if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data);
    else n_pass++;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
    else n_pass++;
    n_checks++;
    if (timeout_count !== 16'h0) $display("FAIL reset_timeout_count: got %h expected 0", timeout_count);
    else n_pass++;
  endtask

  // Requester 0 sends "AB\n" with the serializer always ready.
  task automatic test_single_msg();
    apply_reset();
    req_valid      = 4'b0001;
    req_data[7:0]  = 8'h41;
    @(negedge clock);
    n_checks++;
    if (grant !== 4'b0000) $display("FAIL single_arb_cycle: grant %b expected 0000", grant);
    else n_pass++;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++;
    if ({grant, tx_valid, tx_data, req_ready} !== {4'b0001, 1'b1, 8'h41, 4'b0001})
      $display("FAIL single_byte0: grant %b valid %b data %h ready %b expected 0001 1 41 0001",
               grant, tx_valid, tx_data, req_ready);
    else n_pass++;
    @(posedge clock); #1;
    req_data[7:0] = 8'h42;
    @(negedge clock);
    n_checks++;
    if (tx_data !== 8'h42) $display("FAIL single_byte1: got %h expected 42", tx_data);
    else n_pass++;
    @(posedge clock); #1;
    req_data[7:0] = 8'h0A;
    @(negedge clock);
    n_checks++;
    if ({busy, tx_data} !== {1'b1, 8'h0A})
      $display("FAIL single_byte2: busy %b data %h expected 1 0a", busy, tx_data);
    else n_pass++;
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    n_checks++;
    if ({busy, grant} !== 5'b0)
      $display("FAIL single_end: busy %b grant %b expected 0 0000", busy, grant);
    else n_pass++;
    @(posedge clock); #1;
  endtask

  // Requesters 0 and 1 both offer 3-byte messages continuously.
  task automatic test_contention();
    int exp_c[12] = '{-1, 'h10, 'h11, 'h12, -1, 'h20, 'h21, 'h22, -1, 'h10, 'h11, 'h12};
    int p0;
    int p1;
    int obs;
    logic [N-1:0] acc;
    apply_reset();
    p0 = 0;
    p1 = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid       = 4'b0011;
      req_data[7:0]   = 8'h10 + 8'(p0);
      req_last[0]     = (p0 == 2);
      req_data[15:8]  = 8'h20 + 8'(p1);
      req_last[1]     = (p1 == 2);
      @(negedge clock);
      obs = (tx_valid && tx_ready) ? int'(tx_data) : -1;
      n_checks++;
      if (obs !== exp_c[c]) $display("FAIL contention_cycle%0d: tx %0d expected %0d", c, obs, exp_c[c]);
      else n_pass++;
      if (grant[0]) begin
        n_checks++;
        if (req_ready[1] !== 1'b0) $display("FAIL contention_hold_r1: ready %b expected 0", req_ready[1]);
        else n_pass++;
      end
      acc = req_valid & req_ready;
      @(posedge clock); #1;
      if (acc[0]) p0 = (p0 + 1) % 3;
      if (acc[1]) p1 = (p1 + 1) % 3;
    end
    req_valid = '0;
  endtask

  // Owner sends four bytes while txReady alternates 1,0,1,0.
  task automatic test_backpressure();
    logic [7:0] got[4];
    int ngot;
    int last_cyc;
    int p;
    logic [N-1:0] acc;
    apply_reset();
    ngot     = 0;
    last_cyc = -1;
    p        = 0;
    for (int c = 0; c < 12; c++) begin
      req_valid[0]  = (p < 4);
      req_data[7:0] = 8'h31 + 8'(p);
      req_last[0]   = (p == 3);
      tx_ready      = (c % 2 == 1);
      @(negedge clock);
      if (busy) begin
        n_checks++;
        if (req_ready !== {3'b000, tx_ready})
          $display("FAIL bp_ready_mirror%0d: ready %b expected %b", c, req_ready, {3'b000, tx_ready});
        else n_pass++;
      end
      acc = req_valid & req_ready;
      if (tx_valid && tx_ready && ngot < 4) begin
        got[ngot] = tx_data;
        ngot++;
        last_cyc  = c;
      end
      @(posedge clock); #1;
      if (acc[0]) p++;
    end
    n_checks++;
    if (ngot !== 4) $display("FAIL bp_count: got %0d bytes expected 4", ngot);
    else n_pass++;
    n_checks++;
    if ({got[0], got[1], got[2], got[3]} !== 32'h31323334)
      $display("FAIL bp_bytes: got %h%h%h%h expected 31323334", got[0], got[1], got[2], got[3]);
    else n_pass++;
    n_checks++;
    if (last_cyc !== 7) $display("FAIL bp_last_cycle: got %0d expected 7", last_cyc);
    else n_pass++;
    req_valid = '0;
    tx_ready  = 1'b1;
  endtask

  // r0 sends one non-last byte then stalls while r1 keeps requesting.
  task automatic test_timeout();
    logic [N-1:0] g_log[1000];
    logic [15:0]  tc_log[1000];
    int cycles;
    apply_reset();
    cycles          = TimeoutEn ? 22 : 1000;
    req_valid       = 4'b0011;
    req_data[7:0]   = 8'h55;
    req_last[0]     = 1'b0;
    req_data[15:8]  = 8'h66;
    req_last[1]     = 1'b1;
    tx_ready        = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      g_log[c]  = grant;
      tc_log[c] = timeout_count;
      @(posedge clock); #1;
      if (c == 1) req_valid[0] = 1'b0;
    end
`ifdef OC_UART_TX_ARB_TIMEOUT_EN
    n_checks++;
    if (g_log[17] !== 4'b0001) $display("FAIL to_held_last_idle: grant %b expected 0001", g_log[17]);
    else n_pass++;
    n_checks++;
    if (g_log[18] !== 4'b0000) $display("FAIL to_release: grant %b expected 0000", g_log[18]);
    else n_pass++;
    n_checks++;
    if (g_log[19] !== 4'b0010) $display("FAIL to_next_grant: grant %b expected 0010", g_log[19]);
    else n_pass++;
    n_checks++;
    if (tc_log[19] !== 16'd1) $display("FAIL to_count: got %0d expected 1", tc_log[19]);
    else n_pass++;
`else
    begin
      int off_owner;
      off_owner = 0;
      for (int c = 1; c < 1000; c++) if (g_log[c] !== 4'b0001) off_owner++;
      n_checks++;
      if (off_owner !== 0) $display("FAIL noto_hold: %0d cycles off owner expected 0", off_owner);
      else n_pass++;
      n_checks++;
      if (tc_log[999] !== 16'd0) $display("FAIL noto_count: got %0d expected 0", tc_log[999]);
      else n_pass++;
    end
`endif
    req_valid = '0;
  endtask

  // Reset asserted while r2 owns the UART, then all four request.
  task automatic test_reset_mid();
    apply_reset();
    req_valid        = 4'b0100;
    req_data[23:16]  = 8'h77;
    tx_ready         = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    n_checks++;
    if (grant !== 4'b0100) $display("FAIL rmid_pre_grant: grant %b expected 0100", grant);
    else n_pass++;
    tx_ready = 1'b1;
    #2;
    resetN = 1'b0;
    #1;
    n_checks++;
    if ({grant, busy, tx_valid, tx_data, req_ready, timeout_count} !== '0)
      $display("FAIL rmid_async: grant %b busy %b valid %b data %h ready %b tc %0d expected all 0",
               grant, busy, tx_valid, tx_data, req_ready, timeout_count);
    else n_pass++;
    req_valid = 4'b1111;
    req_data  = 32'h44332211;
    req_last  = 4'b1111;
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL rmid_first_grant: grant %b expected 0001", grant);
    else n_pass++;
    req_valid = '0;
  endtask

  // Random traffic from four requesters compared against the model every cycle.
  task automatic test_random();
    logic [7:0] byte_mem[N][128];
    bit         last_mem[N][128];
    int         n_bytes[N];
    int         rd[N];
    int         cyc;
    bit         done;
    logic [N-1:0] acc;
    logic [N-1:0] e_grant;
    logic [7:0]   e_data;
    logic [N-1:0] e_ready;
    logic [46:0]  e_vec;
    logic [46:0]  a_vec;
    apply_reset();
    for (int i = 0; i < N; i++) begin
      n_bytes[i] = 0;
      rd[i]      = 0;
      while (n_bytes[i] < 60) begin
        int len;
        len = $urandom_range(1, 5);
        for (int j = 0; j < len; j++) begin
          byte_mem[i][n_bytes[i]] = 8'($urandom_range(0, 255));
          last_mem[i][n_bytes[i]] = (j == len - 1);
          n_bytes[i]++;
        end
      end
    end
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 4000) begin
      @(negedge clock);
      e_grant = '0;
      e_data  = '0;
      e_ready = '0;
      if (m_busy) begin
        e_grant[m_owner] = 1'b1;
        e_data           = req_data[8*m_owner +: 8];
        e_ready[m_owner] = tx_ready;
      end
      e_vec = {e_grant, m_busy, m_busy && req_valid[m_owner], e_data, e_ready, 16'(m_tcount)};
      a_vec = {grant, busy, tx_valid, tx_data, req_ready, timeout_count};
      n_checks++;
      if (a_vec !== e_vec)
        $display("FAIL random_cycle%0d: {grant,busy,valid,data,ready,tc} got %h expected %h",
                 cyc, a_vec, e_vec);
      else n_pass++;
      acc = req_valid & req_ready;
      model_next();
      @(posedge clock); #1;
      done = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) rd[i]++;
        if (acc[i] || !req_valid[i])
          req_valid[i] = (rd[i] < n_bytes[i]) && ($urandom_range(0, 3) != 0);
        if (req_valid[i]) begin
          req_data[8*i +: 8] = byte_mem[i][rd[i]];
          req_last[i]        = last_mem[i][rd[i]];
        end
        if (rd[i] < n_bytes[i]) done = 1'b0;
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      cyc++;
    end
    n_checks++;
    if (!done) $display("FAIL random_drain: traffic not drained within %0d cycles", cyc);
    else n_pass++;
    req_valid = '0;
    tx_ready  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_msg();
    test_contention();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
